// File: rtl/ksa_pkg.sv
// ---------------------------------------------------------------------------
// ksa_pkg
// Shared definitions for the wide Kogge-Stone add/subtract slice:
//   - KSA_W   : width of one adder slice (the external combinational adder)
//   - state_e : controller states of ksa_wide_sequencer
// ---------------------------------------------------------------------------
package ksa_pkg;

    localparam int KSA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : ksa_pkg

// File: rtl/ksa_adder.sv
// ---------------------------------------------------------------------------
// ksa_adder
// Combinational W-bit Kogge-Stone adder with carry-in and carry-out.
// This is the slice adder that sits beside ksa_wide_sequencer.
//
// Ports:
//   a    in  W  addend A
//   b    in  W  addend B
//   cin  in  1  carry into bit 0
//   sum  out W  a + b + cin (low W bits)
//   cout out 1  carry out of bit W-1
// ---------------------------------------------------------------------------
module ksa_adder
    import ksa_pkg::*;
#(
    parameter int W = KSA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int LOG = $clog2(W);

    // Row s holds group generate/propagate spanning 2^s bits ending at bit i.
    logic [LOG:0][W-1:0] gen;
    logic [LOG:0][W-1:0] prop;
    logic [W:0]          carry;
    logic [W-1:0]        halfSum;

    // Propagate/generate, log2(W) prefix stages, then carries and sum.
    // Everything lives in one block so the bit-level dependencies between
    // prefix rows resolve in program order.
    always_comb begin
        gen     = '0;
        prop    = '0;
        carry   = '0;
        halfSum = a ^ b;
        gen[0]  = a & b;
        prop[0] = a ^ b;
        for (int s = 0; s < LOG; s++) begin
            for (int i = 0; i < W; i++) begin
                if (i >= (1 << s)) begin
                    gen[s+1][i]  = gen[s][i] | (prop[s][i] & gen[s][i-(1<<s)]);
                    prop[s+1][i] = prop[s][i] & prop[s][i-(1<<s)];
                end else begin
                    gen[s+1][i]  = gen[s][i];
                    prop[s+1][i] = prop[s][i];
                end
            end
        end
        // The final row spans bits [i:0]; folding cin in here gives every
        // carry without another prefix level.
        carry[0] = cin;
        for (int i = 0; i < W; i++) begin
            carry[i+1] = gen[LOG][i] | (prop[LOG][i] & cin);
        end
    end

    assign sum  = halfSum ^ carry[W-1:0];
    assign cout = carry[W];

endmodule : ksa_adder

// File: rtl/ksa_wide_sequencer.sv
// ---------------------------------------------------------------------------
// ksa_wide_sequencer
// Performs a WORDS*W-bit add or subtract by feeding one W-bit slice per cycle
// (least significant first) through an external combinational adder, keeping
// the inter-slice carry in a register.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake; op_sub, a, b sampled on accept
//   adder_a/b/cin          slice operands to the external adder (0 outside RUN)
//   adder_sum/cout         combinational result back from the adder
//   out_valid/out_ready    result handshake
//   sum, carry_out         assembled result and final carry (sub: 1 = no borrow)
//   overflow               two's-complement signed overflow
// ---------------------------------------------------------------------------
module ksa_wide_sequencer
    import ksa_pkg::*;
#(
    parameter int W     = KSA_W,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [W*WORDS-1:0] a,
    input  logic [W*WORDS-1:0] b,
    output logic [W-1:0]     adder_a,
    output logic [W-1:0]     adder_b,
    output logic             adder_cin,
    input  logic [W-1:0]     adder_sum,
    input  logic             adder_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W*WORDS-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int                N        = W * WORDS;
    localparam int                IDX_W    = $clog2(WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    state_e           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic [N-1:0]     opa_q,    opa_d;
    logic [N-1:0]     opb_q,    opb_d;
    logic [N-1:0]     sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic             opaMsb;
    logic             opbMsb;

    // opb is stored already inverted for subtract, so the sign test for
    // overflow is the plain "same input signs, different result sign" rule.
    assign opaMsb = opa_q[N-1];
    assign opbMsb = opb_q[N-1];

    // Next-state logic. A subtract is A + ~B + 1: the inversion happens at
    // latch time and the +1 enters as the initial carry register value.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = op_sub ? ~b : b;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*W +: W] = adder_sum;
                carry_d             = adder_cout;
                if (idx_q == LAST_IDX) begin
                    // The top slice's msb is the sign of the full result.
                    cout_d  = adder_cout;
                    ovf_d   = (opaMsb == opbMsb) && (adder_sum[W-1] != opaMsb);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset discards any partial result and clears the
    // visible result so no stale value survives a mid-operation reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Adder drive: the current slice during RUN, quiet zeros otherwise so the
    // external adder does not toggle while idle.
    always_comb begin
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        if (state_q == ST_RUN) begin
            adder_a   = opa_q[idx_q*W +: W];
            adder_b   = opb_q[idx_q*W +: W];
            adder_cin = carry_q;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule : ksa_wide_sequencer
